// File: rtl/cpu_debug_mem_access.sv
// Debug memory access engine: turns wrapper strobes + jdo into single-word reads/writes with address auto-increment.
// Optional stall timeout is compiled in when DEBUG_MEM_TIMEOUT_EN is defined.
module cpu_debug_mem_access #(
    parameter int ADDR_W  = 9,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    input  logic [31:0]       mem_readdata,
    input  logic              mem_waitrequest,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error
);

    // Memory handshake: a request (mem_read or mem_write) stays high with stable
    // address/data until a cycle where mem_waitrequest is low; that edge completes it.
    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] addr;
    logic              incr_pending;
    logic              any_strobe;
    logic              multi_strobe;
    logic              start_rd;
    logic              start_wr;
    logic              busy;
    logic              xfer_done;
    logic              xfer_abort;
    logic [3:0]        unused_jdo;

    assign unused_jdo   = {jdo[37], jdo[2:0]};
    assign mem_address  = addr;
    assign any_strobe   = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    assign multi_strobe = (take_action_ocimem_a & take_action_ocimem_b) |
                          (take_action_ocimem_a & take_no_action_ocimem_a) |
                          (take_action_ocimem_b & take_no_action_ocimem_a);
    assign start_rd     = take_action_ocimem_a ? jdo[35]
                                               : (!take_action_ocimem_b && take_no_action_ocimem_a);
    assign start_wr     = !take_action_ocimem_a && take_action_ocimem_b;
    assign busy         = (state != IDLE);
    assign xfer_done    = busy && !mem_waitrequest;

`ifdef DEBUG_MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] stall_cnt;

    // Abort on the TIMEOUT-th consecutive stalled edge of one transfer.
    assign xfer_abort = busy && mem_waitrequest && (stall_cnt == TMO_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
        end else if (!busy || !mem_waitrequest) begin
            stall_cnt <= '0;
        end else begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end
`else
    logic [31:0] unused_timeout;

    assign unused_timeout = TIMEOUT;
    assign xfer_abort     = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start_rd) begin
                    state_next = READ;
                end else if (start_wr) begin
                    state_next = WRITE;
                end
            end
            READ, WRITE: begin
                if (xfer_done || xfer_abort) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr          <= '0;
            incr_pending  <= 1'b0;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            mem_writedata <= '0;
            MonDReg       <= '0;
            monitor_ready <= 1'b1;
            monitor_error <= 1'b0;
        end else begin
            // Request flops mirror the next state so they rise/fall with it.
            mem_read  <= (state_next == READ);
            mem_write <= (state_next == WRITE);

            if (!busy) begin
                if (take_action_ocimem_a) begin
                    addr <= jdo[ADDR_W+25:26];
                    if (jdo[36]) begin
                        monitor_error <= 1'b0;
                    end
                    if (jdo[35]) begin
                        monitor_ready <= 1'b0;
                        incr_pending  <= 1'b0;
                    end
                end else if (take_action_ocimem_b) begin
                    mem_writedata <= jdo[34:3];
                    monitor_ready <= 1'b0;
                    incr_pending  <= 1'b1;
                end else if (take_no_action_ocimem_a) begin
                    monitor_ready <= 1'b0;
                    incr_pending  <= 1'b1;
                end
                // Dropped lower-priority strobes win over a same-cycle error clear.
                if (multi_strobe) begin
                    monitor_error <= 1'b1;
                end
            end else begin
                if (any_strobe) begin
                    monitor_error <= 1'b1;
                end
                if (xfer_done) begin
                    monitor_ready <= 1'b1;
                    if (state == READ) begin
                        MonDReg <= mem_readdata;
                    end
                    if (incr_pending) begin
                        addr <= addr + ADDR_W'(1);
                    end
                end else if (xfer_abort) begin
                    monitor_ready <= 1'b1;
                    monitor_error <= 1'b1;
                    if (state == READ) begin
                        MonDReg <= 32'hDEADBEEF;
                    end
                end
            end
        end
    end

endmodule
